bomb_pool_arbiter: RTL and testbench

Two-player bomb-slot arbiter that shares a fixed pool of bomb blocks between player 0 and player 1. It detects each player's drop-key press and checks that player's bomb quota. It then allocates a free bomb block, pulses that block's drop input, and records the owning player. Blast pulses from the bomb blocks free the slot and refund the bomb to its owner. The block sits between the keyboard/player logic and the bomb-block instances, replacing per-player inventory logic.

---
 rtl/bomb_pool_arbiter.sv | 157 +++++++++++++++
 tb/tb_bomb_pool_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_pool_arbiter.sv
// ============================================================================
// bomb_pool_arbiter: shares NUM_SLOTS bomb blocks between two players with quotas.
// Optional BOMB_POOL_RR_EN: round-robin priority for contested single-slot cycles.
// Rev 1.0
// ============================================================================
`default_nettype none

module bomb_pool_arbiter #(
  parameter int NUM_SLOTS   = 3,
  parameter int START_QUOTA = 2,
  parameter int MAX_QUOTA   = 3
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 score_reset,
  input  logic                 drop_key_p0,
  input  logic                 drop_key_p1,
  input  logic                 inc_bomb_p0,
  input  logic                 inc_bomb_p1,
  input  logic [NUM_SLOTS-1:0] slot_blast,
  output logic [NUM_SLOTS-1:0] slot_drop,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [NUM_SLOTS-1:0] slot_owner,
  output logic                 grant_p0,
  output logic                 grant_p1,
  output logic                 deny_p0,
  output logic                 deny_p1,
  output logic [3:0]           bombs_left_p0,
  output logic [3:0]           bombs_left_p1,
  output logic                 pool_full
);

  localparam logic [3:0] START_Q = 4'(START_QUOTA);
  localparam logic [3:0] MAX_Q   = 4'(MAX_QUOTA);

  logic                 key_q0, key_q1;
  logic [3:0]           cap0, cap1, out0, out1;
  logic [NUM_SLOTS-1:0] free, first_oh, second_oh, blast_hit, grant_oh0, grant_oh1;
  logic                 has_first, has_second;
  logic                 press0, press1, elig0, elig1, g0, g1, prio_w;
  logic [3:0]           refund0, refund1, cap0_n, cap1_n, out0_n, out1_n;
`ifdef BOMB_POOL_RR_EN
  logic                 prio;
  logic                 contested;
`endif

  always_comb begin
    free       = ~slot_active;
    first_oh   = '0;
    second_oh  = '0;
    has_first  = 1'b0;
    has_second = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (free[i] && !has_first) begin
        first_oh[i] = 1'b1;
        has_first   = 1'b1;
      end else if (free[i] && !has_second) begin
        second_oh[i] = 1'b1;
        has_second   = 1'b1;
      end
    end

    press0 = drop_key_p0 & ~key_q0;
    press1 = drop_key_p1 & ~key_q1;
    elig0  = press0 && (bombs_left_p0 != 4'd0) && has_first;
    elig1  = press1 && (bombs_left_p1 != 4'd0) && has_first;
`ifdef BOMB_POOL_RR_EN
    prio_w    = prio;
    contested = 1'b0;
`else
    prio_w    = 1'b0;
`endif

    g0        = elig0;
    g1        = elig1;
    grant_oh0 = '0;
    grant_oh1 = '0;
    if (elig0 && elig1) begin
      if (has_second) begin
        grant_oh0 = prio_w ? second_oh : first_oh;
        grant_oh1 = prio_w ? first_oh  : second_oh;
      end else begin
        // One slot, two claimants: only the priority player gets it
`ifdef BOMB_POOL_RR_EN
        contested = 1'b1;
`endif
        g0 = !prio_w;
        g1 = prio_w;
        if (prio_w) grant_oh1 = first_oh;
        else        grant_oh0 = first_oh;
      end
    end else begin
      if (elig0) grant_oh0 = first_oh;
      if (elig1) grant_oh1 = first_oh;
    end

    blast_hit = slot_blast & slot_active;
    refund0   = 4'd0;
    refund1   = 4'd0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (blast_hit[i] && !slot_owner[i]) refund0 = refund0 + 4'd1;
      else if (blast_hit[i])              refund1 = refund1 + 4'd1;
    end

    cap0_n = cap0 + 4'((inc_bomb_p0 && (cap0 < MAX_Q)) ? 1 : 0);
    cap1_n = cap1 + 4'((inc_bomb_p1 && (cap1 < MAX_Q)) ? 1 : 0);
    out0_n = out0 + 4'(g0) - refund0;
    out1_n = out1 + 4'(g1) - refund1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_q0 <= 1'b0;  key_q1 <= 1'b0;
      cap0 <= START_Q; cap1 <= START_Q;
      out0 <= 4'd0;    out1 <= 4'd0;
      slot_drop <= '0; slot_active <= '0; slot_owner <= '0;
      grant_p0 <= 1'b0; grant_p1 <= 1'b0; deny_p0 <= 1'b0; deny_p1 <= 1'b0;
      bombs_left_p0 <= START_Q; bombs_left_p1 <= START_Q;
    end else if (score_reset) begin
      key_q0 <= 1'b0;  key_q1 <= 1'b0;
      cap0 <= START_Q; cap1 <= START_Q;
      out0 <= 4'd0;    out1 <= 4'd0;
      slot_drop <= '0; slot_active <= '0; slot_owner <= '0;
      grant_p0 <= 1'b0; grant_p1 <= 1'b0; deny_p0 <= 1'b0; deny_p1 <= 1'b0;
      bombs_left_p0 <= START_Q; bombs_left_p1 <= START_Q;
    end else begin
      key_q0 <= drop_key_p0;
      key_q1 <= drop_key_p1;
      cap0 <= cap0_n;  cap1 <= cap1_n;
      out0 <= out0_n;  out1 <= out1_n;
      // Granted slots were free, so they never overlap the blasting ones
      slot_drop   <= grant_oh0 | grant_oh1;
      slot_active <= (slot_active & ~blast_hit) | grant_oh0 | grant_oh1;
      slot_owner  <= (slot_owner & ~grant_oh0) | grant_oh1;
      grant_p0 <= g0;
      grant_p1 <= g1;
      deny_p0  <= press0 & ~g0;
      deny_p1  <= press1 & ~g1;
      bombs_left_p0 <= cap0_n - out0_n;
      bombs_left_p1 <= cap1_n - out1_n;
    end
  end

`ifdef BOMB_POOL_RR_EN
  // Priority passes to the loser of a contested single-slot cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)          prio <= 1'b0;
    else if (score_reset) prio <= 1'b0;
    else if (contested)   prio <= ~prio;
  end
`endif

  assign pool_full = &slot_active;

endmodule

`default_nettype wire

// File: tb/tb_bomb_pool_arbiter.sv
// Directed testbench for bomb_pool_arbiter (NUM_SLOTS=3, START_QUOTA=2, MAX_QUOTA=3).
`default_nettype none

module tb_bomb_pool_arbiter;
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       score_reset = 1'b0;
  logic       drop_key_p0 = 1'b0, drop_key_p1 = 1'b0;
  logic       inc_bomb_p0 = 1'b0, inc_bomb_p1 = 1'b0;
  logic [2:0] slot_blast = 3'b000;
  logic [2:0] slot_drop, slot_active, slot_owner;
  logic       grant_p0, grant_p1, deny_p0, deny_p1, pool_full;
  logic [3:0] bombs_left_p0, bombs_left_p1;
  int         tests_run = 0;
  int         fail_count = 0;

  bomb_pool_arbiter #(.NUM_SLOTS(3), .START_QUOTA(2), .MAX_QUOTA(3)) dut (
    .clk(clk), .resetN(resetN), .score_reset(score_reset),
    .drop_key_p0(drop_key_p0), .drop_key_p1(drop_key_p1),
    .inc_bomb_p0(inc_bomb_p0), .inc_bomb_p1(inc_bomb_p1),
    .slot_blast(slot_blast), .slot_drop(slot_drop), .slot_active(slot_active),
    .slot_owner(slot_owner), .grant_p0(grant_p0), .grant_p1(grant_p1),
    .deny_p0(deny_p0), .deny_p1(deny_p1), .bombs_left_p0(bombs_left_p0),
    .bombs_left_p1(bombs_left_p1), .pool_full(pool_full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({slot_drop, slot_active, slot_owner, grant_p0, grant_p1, deny_p0, deny_p1, pool_full} !== 14'd0) begin
      fail_count++; $display("FAIL reset_ctrl: got drop=%b act=%b own=%b full=%b want zeros", slot_drop, slot_active, slot_owner, pool_full);
    end
    tests_run++;
    if ({bombs_left_p0, bombs_left_p1} !== 8'h22) begin
      fail_count++; $display("FAIL reset_left: got %0d/%0d want 2/2", bombs_left_p0, bombs_left_p1);
    end
    resetN = 1'b1;
    step();
  endtask

  task automatic test_single_press();
    drop_key_p0 = 1'b1;
    step();
    tests_run++;
    if ({slot_drop, grant_p0, slot_owner[0], slot_active, bombs_left_p0} !== {3'b001, 1'b1, 1'b0, 3'b001, 4'd1}) begin
      fail_count++; $display("FAIL single_press: got drop=%b g=%b own0=%b act=%b left=%0d want 001 1 0 001 1", slot_drop, grant_p0, slot_owner[0], slot_active, bombs_left_p0);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if ({slot_drop, grant_p0, deny_p0} !== 5'd0) begin
        fail_count++; $display("FAIL hold_key: cycle %0d got drop=%b g=%b d=%b want 0", i, slot_drop, grant_p0, deny_p0);
      end
    end
    drop_key_p0 = 1'b0; step();
    drop_key_p0 = 1'b1; step();
    tests_run++;
    if ({slot_drop, bombs_left_p0} !== {3'b010, 4'd0}) begin
      fail_count++; $display("FAIL second_press: got drop=%b left=%0d want 010 0", slot_drop, bombs_left_p0);
    end
    drop_key_p0 = 1'b0; step();
    drop_key_p0 = 1'b1; step();
    tests_run++;
    if ({deny_p0, grant_p0, slot_drop, bombs_left_p0} !== {1'b1, 1'b0, 3'b000, 4'd0}) begin
      fail_count++; $display("FAIL quota_deny: got d=%b g=%b drop=%b left=%0d want 1 0 000 0", deny_p0, grant_p0, slot_drop, bombs_left_p0);
    end
    step();
    tests_run++;
    if (deny_p0 !== 1'b0) begin
      fail_count++; $display("FAIL deny_width: got %b want 0", deny_p0);
    end
    drop_key_p0 = 1'b0; step();
    slot_blast = 3'b001; step();
    slot_blast = 3'b000;
    tests_run++;
    if ({slot_active, bombs_left_p0} !== {3'b010, 4'd1}) begin
      fail_count++; $display("FAIL blast_refund: got act=%b left=%0d want 010 1", slot_active, bombs_left_p0);
    end
  endtask

  task automatic test_contested();
    drop_key_p1 = 1'b1; step();
    tests_run++;
    if ({slot_drop, grant_p1, slot_owner[0]} !== {3'b001, 1'b1, 1'b1}) begin
      fail_count++; $display("FAIL p1_lowest: got drop=%b g1=%b own0=%b want 001 1 1", slot_drop, grant_p1, slot_owner[0]);
    end
    drop_key_p1 = 1'b0; step();
    drop_key_p0 = 1'b1; drop_key_p1 = 1'b1; step();
    tests_run++;
    if ({slot_drop, grant_p0, deny_p1, grant_p1, deny_p0, bombs_left_p0} !== {3'b100, 4'b1100, 4'd0}) begin
      fail_count++; $display("FAIL contest1: got drop=%b g0=%b d1=%b g1=%b d0=%b left0=%0d want 100 1 1 0 0 0", slot_drop, grant_p0, deny_p1, grant_p1, deny_p0, bombs_left_p0);
    end
    drop_key_p0 = 1'b0; drop_key_p1 = 1'b0; step();
    slot_blast = 3'b100; step();
    slot_blast = 3'b000;
    drop_key_p0 = 1'b1; drop_key_p1 = 1'b1; step();
`ifdef BOMB_POOL_RR_EN
    tests_run++;
    if ({slot_drop, grant_p1, deny_p0, grant_p0, deny_p1, bombs_left_p1} !== {3'b100, 4'b1100, 4'd0}) begin
      fail_count++; $display("FAIL contest2_rr: got drop=%b g1=%b d0=%b g0=%b d1=%b left1=%0d want 100 1 1 0 0 0", slot_drop, grant_p1, deny_p0, grant_p0, deny_p1, bombs_left_p1);
    end
`else
    tests_run++;
    if ({slot_drop, grant_p0, deny_p1, grant_p1, deny_p0, bombs_left_p0} !== {3'b100, 4'b1100, 4'd0}) begin
      fail_count++; $display("FAIL contest2_fixed: got drop=%b g0=%b d1=%b g1=%b d0=%b left0=%0d want 100 1 1 0 0 0", slot_drop, grant_p0, deny_p1, grant_p1, deny_p0, bombs_left_p0);
    end
`endif
    tests_run++;
    if (pool_full !== 1'b1) begin
      fail_count++; $display("FAIL pool_full: got %b want 1", pool_full);
    end
    drop_key_p0 = 1'b0; drop_key_p1 = 1'b0; step();
  endtask

  task automatic test_pool_full_blast();
    logic [3:0] exp_after, exp_regrant;
`ifdef BOMB_POOL_RR_EN
    exp_after = 4'd2; exp_regrant = 4'd1;
`else
    exp_after = 4'd1; exp_regrant = 4'd0;
`endif
    slot_blast = 3'b010; drop_key_p0 = 1'b1; step();
    slot_blast = 3'b000; drop_key_p0 = 1'b0;
    tests_run++;
    if ({deny_p0, grant_p0, slot_drop, slot_active, bombs_left_p0} !== {2'b10, 3'b000, 3'b101, exp_after}) begin
      fail_count++; $display("FAIL full_blast_deny: got d=%b g=%b drop=%b act=%b left=%0d want 1 0 000 101 %0d", deny_p0, grant_p0, slot_drop, slot_active, bombs_left_p0, exp_after);
    end
    step();
    drop_key_p0 = 1'b1; step();
    drop_key_p0 = 1'b0;
    tests_run++;
    if ({slot_drop, grant_p0, bombs_left_p0} !== {3'b010, 1'b1, exp_regrant}) begin
      fail_count++; $display("FAIL reuse_slot: got drop=%b g=%b left=%0d want 010 1 %0d", slot_drop, grant_p0, bombs_left_p0, exp_regrant);
    end
    step();
  endtask

  task automatic test_score_reset();
    score_reset = 1'b1; step();
    score_reset = 1'b0;
    tests_run++;
    if ({slot_active, slot_drop, pool_full, bombs_left_p0, bombs_left_p1} !== {7'd0, 8'h22}) begin
      fail_count++; $display("FAIL score_reset: got act=%b drop=%b full=%b left=%0d/%0d want 000 000 0 2/2", slot_active, slot_drop, pool_full, bombs_left_p0, bombs_left_p1);
    end
    slot_blast = 3'b111; step();
    slot_blast = 3'b000;
    tests_run++;
    if ({slot_active, bombs_left_p0, bombs_left_p1} !== {3'b000, 8'h22}) begin
      fail_count++; $display("FAIL stale_blast: got act=%b left=%0d/%0d want 000 2/2", slot_active, bombs_left_p0, bombs_left_p1);
    end
  endtask

  task automatic test_both_free();
    drop_key_p0 = 1'b1; drop_key_p1 = 1'b1; step();
    drop_key_p0 = 1'b0; drop_key_p1 = 1'b0;
    tests_run++;
    if ({slot_drop, slot_owner, grant_p0, grant_p1, deny_p0, deny_p1} !== {3'b011, 3'b010, 4'b1100}) begin
      fail_count++; $display("FAIL both_free: got drop=%b own=%b g=%b%b d=%b%b want 011 010 11 00", slot_drop, slot_owner, grant_p0, grant_p1, deny_p0, deny_p1);
    end
    step();
  endtask

  task automatic test_inc();
    score_reset = 1'b1; step(); score_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inc_bomb_p1 = 1'b1; step(); inc_bomb_p1 = 1'b0;
      tests_run++;
      if (bombs_left_p1 !== 4'd3) begin
        fail_count++; $display("FAIL inc_sat: pulse %0d got %0d want 3", i, bombs_left_p1);
      end
    end
    score_reset = 1'b1; step(); score_reset = 1'b0;
    drop_key_p1 = 1'b1; inc_bomb_p1 = 1'b1; step();
    drop_key_p1 = 1'b0; inc_bomb_p1 = 1'b0;
    tests_run++;
    if ({grant_p1, slot_drop, bombs_left_p1} !== {1'b1, 3'b001, 4'd2}) begin
      fail_count++; $display("FAIL grant_inc: got g1=%b drop=%b left=%0d want 1 001 2", grant_p1, slot_drop, bombs_left_p1);
    end
    step();
  endtask

  task automatic test_async_reset();
    score_reset = 1'b1; step(); score_reset = 1'b0;
    drop_key_p0 = 1'b1; step();
    tests_run++;
    if (slot_drop !== 3'b001) begin
      fail_count++; $display("FAIL pre_async: got %b want 001", slot_drop);
    end
    #2 resetN = 1'b0;
    #1;
    tests_run++;
    if ({slot_drop, slot_active, grant_p0, bombs_left_p0} !== {7'd0, 4'd2}) begin
      fail_count++; $display("FAIL async_reset: got drop=%b act=%b g=%b left=%0d want 000 000 0 2", slot_drop, slot_active, grant_p0, bombs_left_p0);
    end
    drop_key_p0 = 1'b0;
    @(negedge clk) resetN = 1'b1;
    step();
    tests_run++;
    if (slot_drop !== 3'b000) begin
      fail_count++; $display("FAIL post_async: got %b want 000", slot_drop);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_contested();
    test_pool_full_blast();
    test_score_reset();
    test_both_free();
    test_inc();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

`default_nettype wire
